bp_be_rollback_issue_fifo: RTL and testbench

Parametrised replay buffer that sits between the FE queue and the BE scheduler/decoder. It generalises the fixed-format issue queue to arbitrary entry width and depth, and adds occupancy reporting. It keeps three pointers: write, speculative read (issue) and commit. Issued entries stay resident until commit dequeues them, or until a rollback re-exposes them for replay. A clear drops every uncommitted entry.

---
 rtl/bp_be_rollback_issue_fifo.sv | 54 +++++
 tb/tb_bp_be_rollback_issue_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bp_be_rollback_issue_fifo.sv
// bp_be_rollback_issue_fifo: replay FIFO with write/issue/commit pointers, rollback and clear; define BP_ISSUE_FIFO_BYPASS_EN for same-cycle empty bypass
module bp_be_rollback_issue_fifo #(
  parameter int width_p = 64,
  parameter int els_p = 8,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_v_i,
  input  logic                    deq_v_i,
  input  logic                    roll_v_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [ptr_width_lp-1:0] count_o,
  output logic [ptr_width_lp-1:0] issued_count_o
);
  localparam int idx_w_lp = $clog2(els_p);
  logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next;
  logic [width_p-1:0] mem [els_p];
  logic enq, stored_v;
  assign count_o = wptr - cptr;
  assign issued_count_o = rptr - cptr;
  assign ready_o = count_o != ptr_width_lp'(els_p);
  assign enq = v_i & ready_o & ~clr_v_i;
  assign cptr_next = cptr + ptr_width_lp'(deq_v_i);
  assign stored_v = rptr != wptr;
`ifdef BP_ISSUE_FIFO_BYPASS_EN
  logic byp;
  assign byp = ~stored_v & enq & ~roll_v_i;
  assign v_o = stored_v | byp;
  assign data_o = byp ? data_i : mem[rptr[idx_w_lp-1:0]];
`else
  assign v_o = stored_v;
  assign data_o = mem[rptr[idx_w_lp-1:0]];
`endif
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      cptr <= cptr_next;
      wptr <= clr_v_i ? cptr_next : enq ? wptr + 1'b1 : wptr;
      rptr <= (clr_v_i | roll_v_i) ? cptr_next : yumi_i ? rptr + 1'b1 : rptr;
    end
  always_ff @(posedge clk_i)
    if (enq) mem[wptr[idx_w_lp-1:0]] <= data_i;
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
  assert property (@(posedge clk_i) disable iff (reset_i) deq_v_i |-> issued_count_o != '0);
endmodule

// File: tb/tb_bp_be_rollback_issue_fifo.sv
// tb_bp_be_rollback_issue_fifo: queue-model bench with directed scenarios and randomized legal traffic
module tb_bp_be_rollback_issue_fifo;
  localparam int W = 16;
  localparam int ELS = 8;
  localparam int PW = $clog2(ELS) + 1;
  logic clk = 0;
  logic reset_i, clr_v_i, deq_v_i, roll_v_i, v_i, yumi_i;
  logic [W-1:0] data_i, data_o;
  logic ready_o, v_o;
  logic [PW-1:0] count_o, issued_count_o;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q[$];
  int iss = 0;
  int ni;
  bit menq;
  bp_be_rollback_issue_fifo #(.width_p(W), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i), .clr_v_i(clr_v_i), .deq_v_i(deq_v_i),
    .roll_v_i(roll_v_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .count_o(count_o),
    .issued_count_o(issued_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit m_byp();
`ifdef BP_ISSUE_FIFO_BYPASS_EN
    return iss == q.size() && v_i && q.size() != ELS && !clr_v_i && !roll_v_i;
`else
    return 0;
`endif
  endfunction
  always @(posedge clk)
    if (reset_i) begin
      q.delete();
      iss = 0;
    end else begin
      menq = v_i && q.size() != ELS && !clr_v_i;
      ni = iss;
      if (deq_v_i) begin
        void'(q.pop_front());
        ni--;
      end
      if (clr_v_i) begin
        q.delete();
        ni = 0;
      end else begin
        if (menq) q.push_back(data_i);
        if (roll_v_i) ni = 0;
        else if (yumi_i) ni++;
      end
      iss = ni;
    end
  always @(negedge clk)
    if (!reset_i) begin
      chk("ready", ready_o, q.size() != ELS);
      chk("count", count_o, q.size());
      chk("issued_count", issued_count_o, iss);
      chk("v_o", v_o, iss < q.size() || m_byp());
      if (m_byp()) chk("data_byp", data_o, data_i);
      else if (iss < q.size()) chk("data_o", data_o, q[iss]);
    end
  task automatic idle();
    {clr_v_i, deq_v_i, roll_v_i, v_i, yumi_i} = '0;
    data_i = '0;
  endtask
  task automatic step(bit v, logic [W-1:0] d, bit y, bit dq, bit rl, bit cl);
    v_i = v; data_i = d; yumi_i = y; deq_v_i = dq; roll_v_i = rl; clr_v_i = cl;
    @(posedge clk); #1;
    idle();
    #1;
  endtask
  initial begin
    int exp_out;
    idle();
    reset_i = 1;
    repeat (2) @(posedge clk);
    #1 reset_i = 0;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_v", v_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_issued", issued_count_o, 0);
    for (int i = 0; i < 8; i++) step(1, W'(16'hA0 + i), 0, 0, 0, 0);
    chk("full_ready", ready_o, 0);
    chk("full_count", count_o, 8);
    chk("full_v", v_o, 1);
    chk("full_data", data_o, 16'hA0);
    step(1, 16'hA8, 0, 0, 0, 0);
    chk("ninth_count", count_o, 8);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("roll_issued", issued_count_o, 0);
    chk("roll_count", count_o, 7);
    chk("roll_data", data_o, 16'hA1);
    for (int i = 0; i < 3; i++) begin
      chk("replay_data", data_o, W'(16'hA1 + i));
      step(0, 0, 1, 0, 0, 0);
    end
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(1, 16'hB0, 0, 1, 0, 1);
    chk("clr_count", count_o, 0);
    chk("clr_v", v_o, 0);
    chk("clr_ready", ready_o, 1);
    step(1, 16'hC0, 0, 0, 0, 0);
    chk("post_clr_data", data_o, 16'hC0);
    chk("post_clr_count", count_o, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    exp_out = 0;
    for (int i = 0; i < 24; i++) begin
      v_i = i < 20; data_i = W'(i);
      yumi_i = iss < q.size(); deq_v_i = iss > 0;
      #1;
      if (yumi_i) begin
        chk("wrap_order", data_o, exp_out);
        exp_out++;
      end
      chk("wrap_cnt_le2", count_o <= 2, 1);
      @(posedge clk); #1;
      idle();
      #1;
    end
    chk("wrap_total", exp_out, 20);
    chk("wrap_empty", count_o, 0);
    for (int i = 0; i < 3; i++) step(1, W'(16'hD0 + i), 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    chk("pre_roll_issued", issued_count_o, 2);
    step(0, 0, 1, 1, 1, 0);
    chk("ryd_issued", issued_count_o, 0);
    chk("ryd_count", count_o, 2);
    chk("ryd_data", data_o, 16'hD1);
    step(0, 0, 0, 0, 0, 1);
`ifdef BP_ISSUE_FIFO_BYPASS_EN
    v_i = 1; data_i = 16'h5A; yumi_i = 1;
    #1;
    chk("byp_v", v_o, 1);
    chk("byp_data", data_o, 16'h5A);
    @(posedge clk); #1;
    idle();
    #1;
    chk("byp_issued", issued_count_o, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("byp_replay", data_o, 16'h5A);
    step(0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 800; i++) begin
      reset_i = ($urandom % 300) == 0;
      v_i = $urandom % 3 != 0;
      data_i = W'($urandom);
      yumi_i = iss < q.size() && ($urandom % 2);
      deq_v_i = iss > 0 && ($urandom % 3 != 0);
      roll_v_i = $urandom % 12 == 0;
      clr_v_i = $urandom % 25 == 0;
      @(posedge clk); #1;
      idle();
      reset_i = 0;
      #1;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
